alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the EX-stage ALU. Single-cycle ops (add/sub/logic/compare/branch-on-flag) complete in one cycle. Multiply and divide run on an iterative datapath under a start/busy/done handshake, so the EX stage stalls on `busy`. Holds a persistent flag register that `BRFL` tests, and registers all outputs.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_muldiv_iter.sv | 78 +++++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/func/flag encodings, FSM state type and op-class decode for alu_seq.
package alu_pkg;

  localparam logic [2:0] CTL_ADDI   = 3'b000;
  localparam logic [2:0] CTL_SUBI   = 3'b001;
  localparam logic [2:0] CTL_TYPE_R = 3'b010;
  localparam logic [2:0] CTL_ANDI   = 3'b011;
  localparam logic [2:0] CTL_ORI    = 3'b100;
  localparam logic [2:0] CTL_BRFL   = 3'b101;
  localparam logic [2:0] CTL_CMP    = 3'b110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b000010;
  localparam logic [5:0] FN_DIV = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOT = 6'b100111;

  localparam logic [2:0] FLAG_NONE      = 3'b000;
  localparam logic [2:0] FLAG_EQUAL     = 3'b001;
  localparam logic [2:0] FLAG_EXCEPTION = 3'b010;
  localparam logic [2:0] FLAG_OVERFLOW  = 3'b011;
  localparam logic [2:0] FLAG_UNDERFLOW = 3'b100;
  localparam logic [2:0] FLAG_ABOVE     = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_CMP, OP_BRFL, OP_ILL
  } op_e;

  function automatic op_e decode_op(input logic [2:0] ctl, input logic [5:0] fn);
    op_e op;
    op = OP_ILL;
    case (ctl)
      CTL_ADDI: op = OP_ADD;
      CTL_SUBI: op = OP_SUB;
      CTL_ANDI: op = OP_AND;
      CTL_ORI:  op = OP_OR;
      CTL_BRFL: op = OP_BRFL;
      CTL_CMP:  op = OP_CMP;
      CTL_TYPE_R: begin
        case (fn)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_MUL:  op = OP_MUL;
          FN_DIV:  op = OP_DIV;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_NOT:  op = OP_NOT;
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per step, with its own down-counter.
// Divider datapath is only built when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o,
  output logic             hi_nz_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic           is_div_q;
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;

  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[WIDTH];
    acc_step  = is_div_q
              ? {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
              : mul_step;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      is_div_q <= 1'b0;
    else if (load_i) is_div_q <= is_div_i;
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
  assign acc_step      = mul_step;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(WIDTH - 1);
      acc_q <= {{WIDTH{1'b0}}, a_i};
      opb_q <= b_i;
    end else if (step_i) begin
      acc_q <= acc_step;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Outputs reflect the step in progress so the final bit lands in the same edge as DONE
  assign last_o  = (cnt_q == '0);
  assign res_o   = acc_step[WIDTH-1:0];
  assign hi_nz_o = |acc_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle ops, iterative MUL/DIV, persistent flag register.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV reports EXCEPTION in one cycle.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | iterative MUL/DIV in progress
//   DONE    | done pulse, outputs valid
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FLAG_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  data_a,
  input  logic [WIDTH-1:0]  data_b,
  input  logic [2:0]        alu_control,
  input  logic [5:0]        func,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flag,
  output logic              branch
);

  localparam logic [FLAG_W-1:0] F_NONE  = FLAG_W'(FLAG_NONE);
  localparam logic [FLAG_W-1:0] F_EQ    = FLAG_W'(FLAG_EQUAL);
  localparam logic [FLAG_W-1:0] F_EXC   = FLAG_W'(FLAG_EXCEPTION);
  localparam logic [FLAG_W-1:0] F_OVF   = FLAG_W'(FLAG_OVERFLOW);
  localparam logic [FLAG_W-1:0] F_UNF   = FLAG_W'(FLAG_UNDERFLOW);
  localparam logic [FLAG_W-1:0] F_ABOVE = FLAG_W'(FLAG_ABOVE);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              branch_q, branch_d, busy_q, done_q;
  op_e               op;
  logic [WIDTH-1:0]  sum, diff, md_res;
  logic              load, is_div, md_last, md_hi_nz;
`ifdef ALU_SEQ_DIV_EN
  logic              div_q, div_d, divz_q, divz_d;
`endif

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load),
    .step_i  (state_q == ST_RUN),
    .is_div_i(is_div),
    .a_i     (data_a),
    .b_i     (data_b),
    .last_o  (md_last),
    .res_o   (md_res),
    .hi_nz_o (md_hi_nz)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    branch_d = branch_q;
    load     = 1'b0;
    is_div   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_d    = div_q;
    divz_d   = divz_q;
`endif
    op   = decode_op(alu_control, func);
    sum  = data_a + data_b;
    diff = data_a - data_b;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DONE;
          case (op)
            OP_ADD: begin
              result_d = sum;
              flag_d   = F_NONE;
              if (data_a[WIDTH-1] == data_b[WIDTH-1] && sum[WIDTH-1] != data_a[WIDTH-1])
                flag_d = data_a[WIDTH-1] ? F_UNF : F_OVF;
            end
            OP_SUB: begin
              result_d = diff;
              flag_d   = F_NONE;
              if (data_a[WIDTH-1] != data_b[WIDTH-1] && diff[WIDTH-1] != data_a[WIDTH-1])
                flag_d = data_a[WIDTH-1] ? F_UNF : F_OVF;
            end
            OP_MUL: begin
              load    = 1'b1;
              state_d = ST_RUN;
`ifdef ALU_SEQ_DIV_EN
              div_d   = 1'b0;
`endif
            end
            OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
              load    = 1'b1;
              is_div  = 1'b1;
              state_d = ST_RUN;
              div_d   = 1'b1;
              divz_d  = (data_b == '0);
`else
              result_d = '0;
              flag_d   = F_EXC;
`endif
            end
            OP_AND: result_d = data_a & data_b;
            OP_OR:  result_d = data_a | data_b;
            OP_NOT: result_d = ~data_b;
            OP_CMP: flag_d = (data_a == data_b) ? F_EQ : (data_a > data_b) ? F_ABOVE : F_NONE;
            OP_BRFL: begin
              branch_d = (flag_q == data_b[FLAG_W-1:0]);
              result_d = data_a;
            end
            default: begin
              result_d = '0;
              flag_d   = F_EXC;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (md_last) begin
          state_d  = ST_DONE;
          result_d = md_res;
          flag_d   = md_hi_nz ? F_OVF : F_NONE;
`ifdef ALU_SEQ_DIV_EN
          // For DIV the upper half is the remainder, not an overflow indication
          if (div_q) flag_d = divz_q ? F_EXC : F_NONE;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flag_q   <= F_NONE;
      branch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= 1'b0;
      divz_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      branch_q <= branch_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
`ifdef ALU_SEQ_DIV_EN
      div_q    <= div_d;
      divz_q   <= divz_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign branch = branch_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data_a, data_b;
  logic [2:0]   alu_control;
  logic [5:0]   func;
  logic         busy, done, branch;
  logic [W-1:0] result;
  logic [2:0]   flag;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(W), .FLAG_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .data_a     (data_a),
    .data_b     (data_b),
    .alu_control(alu_control),
    .func       (func),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .flag       (flag),
    .branch     (branch)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic issue(input logic [2:0] ctl, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    alu_control = ctl;
    func        = fn;
    data_a      = a;
    data_b      = b;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // lat counts edges from the accepting edge (1) up to the edge that raised done
  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(posedge clock);
      #1;
      lat++;
    end
    if (busy) bc++;
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [2:0] ctl, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bc);
    issue(ctl, fn, a, b);
    wait_done(1, lat, bc);
  endtask

  int lat, bc, dcnt;
  int div_lat;

  initial begin
`ifdef ALU_SEQ_DIV_EN
    div_lat = W + 1;
`else
    div_lat = 1;
`endif
    reset = 1'b0; start = 1'b0; data_a = '0; data_b = '0; alu_control = '0; func = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst result", result, 0);
    check("rst flag", flag, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst branch", branch, 0);
    reset = 1'b1;

    run_op(CTL_ADDI, 6'd0, 32'h7FFF_FFFF, 32'h1, lat, bc);
    check("addi ovf lat", lat, 1);
    check("addi ovf busy", bc, 1);
    check("addi ovf result", result, 32'h8000_0000);
    check("addi ovf flag", flag, FLAG_OVERFLOW);

    run_op(CTL_TYPE_R, FN_SUB, 32'h8000_0000, 32'h1, lat, bc);
    check("sub unf result", result, 32'h7FFF_FFFF);
    check("sub unf flag", flag, FLAG_UNDERFLOW);

    run_op(CTL_SUBI, 6'd0, 32'd5, 32'd7, lat, bc);
    check("subi neg result", result, 32'hFFFF_FFFE);
    check("subi neg flag", flag, FLAG_NONE);

    run_op(CTL_TYPE_R, FN_MUL, 32'h0001_0000, 32'h0001_0000, lat, bc);
    check("mul big lat", lat, W + 1);
    check("mul big busy", bc, W + 1);
    check("mul big result", result, 0);
    check("mul big flag", flag, FLAG_OVERFLOW);

    run_op(CTL_TYPE_R, FN_MUL, 32'd7, 32'd6, lat, bc);
    check("mul 7x6 result", result, 42);
    check("mul 7x6 flag", flag, FLAG_NONE);

    run_op(CTL_TYPE_R, FN_DIV, 32'd100, 32'd7, lat, bc);
    check("div 100/7 lat", lat, div_lat);
`ifdef ALU_SEQ_DIV_EN
    check("div 100/7 result", result, 14);
    check("div 100/7 flag", flag, FLAG_NONE);
`else
    check("div 100/7 result", result, 0);
    check("div 100/7 flag", flag, FLAG_EXCEPTION);
`endif

    run_op(CTL_TYPE_R, FN_DIV, 32'd5, 32'd0, lat, bc);
    check("div 5/0 lat", lat, div_lat);
`ifdef ALU_SEQ_DIV_EN
    check("div 5/0 result", result, 32'hFFFF_FFFF);
`else
    check("div 5/0 result", result, 0);
`endif
    check("div 5/0 flag", flag, FLAG_EXCEPTION);

    run_op(CTL_ANDI, 6'd0, 32'h0000_F0F0, 32'h0000_FF00, lat, bc);
    check("andi result", result, 32'h0000_F000);
    check("andi flag held", flag, FLAG_EXCEPTION);
    run_op(CTL_ORI, 6'd0, 32'h0F, 32'hF0, lat, bc);
    check("ori result", result, 32'hFF);
    run_op(CTL_TYPE_R, FN_NOT, 32'h1234, 32'h0000_FFFF, lat, bc);
    check("not result", result, 32'hFFFF_0000);

    run_op(CTL_CMP, 6'd0, 32'd9, 32'd9, lat, bc);
    check("cmp eq flag", flag, FLAG_EQUAL);
    check("cmp result held", result, 32'hFFFF_0000);
    run_op(CTL_BRFL, 6'd0, 32'h1234, 32'd1, lat, bc);
    check("brfl eq branch", branch, 1);
    check("brfl result", result, 32'h1234);
    check("brfl flag held", flag, FLAG_EQUAL);
    run_op(CTL_CMP, 6'd0, 32'd3, 32'd9, lat, bc);
    check("cmp lt flag", flag, FLAG_NONE);
    run_op(CTL_BRFL, 6'd0, 32'h55, 32'd1, lat, bc);
    check("brfl ne branch", branch, 0);
    run_op(CTL_CMP, 6'd0, 32'd10, 32'd3, lat, bc);
    check("cmp gt flag", flag, FLAG_ABOVE);
    run_op(CTL_BRFL, 6'd0, 32'h66, 32'd5, lat, bc);
    check("brfl above branch", branch, 1);

    run_op(3'b111, 6'd0, 32'd1, 32'd1, lat, bc);
    check("illegal ctl result", result, 0);
    check("illegal ctl flag", flag, FLAG_EXCEPTION);
    check("illegal branch held", branch, 1);
    run_op(CTL_ADDI, 6'd0, 32'd2, 32'd3, lat, bc);
    check("addi 2+3 flag", flag, FLAG_NONE);
    run_op(CTL_TYPE_R, 6'b111111, 32'd1, 32'd1, lat, bc);
    check("bad func result", result, 0);
    check("bad func flag", flag, FLAG_EXCEPTION);

    // start pulsed mid-RUN must be ignored
    issue(CTL_TYPE_R, FN_MUL, 32'd7, 32'd6);
    repeat (3) begin @(posedge clock); #1; end
    alu_control = CTL_ADDI; data_a = 32'd100; data_b = 32'd200; start = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    start = 1'b0;
    wait_done(6, lat, bc);
    check("mul ignore lat", lat, W + 1);
    check("mul ignore result", result, 42);

    // async reset in the middle of RUN
    issue(CTL_TYPE_R, FN_MUL, 32'hFFFF_FFFF, 32'd2);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    check("midrun rst result", result, 0);
    check("midrun rst flag", flag, 0);
    check("midrun rst busy", busy, 0);
    check("midrun rst done", done, 0);
    check("midrun rst branch", branch, 0);
    #2;
    reset = 1'b1;
    dcnt = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcnt++; end
    check("no done after rst", dcnt, 0);

    run_op(CTL_ADDI, 6'd0, 32'd2, 32'd3, lat, bc);
    check("post rst add", result, 5);
    check("post rst add lat", lat, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
